// File: rtl/rtc_secuenciador.sv
// RTC transaction sequencer: burst-reads the six time registers and issues single writes.
// Define RTC_CMD_TRANSFER_EN to precede every burst with a transfer-command write.
module rtc_secuenciador #(
    parameter logic [7:0] BASE_ADDR = 8'h21,
    parameter int         NUM_REGS  = 6,
    parameter int         TIMEOUT   = 63,
    parameter logic [7:0] CMD_ADDR  = 8'hF0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_lectura,
    input  logic       req_escritura,
    input  logic [2:0] wr_indice,
    input  logic [7:0] wr_dato,
    input  logic       final_tx,
    input  logic       escreg,
    input  logic [7:0] bus_dato,
    output logic [7:0] direccion,
    output logic [7:0] dato,
    output logic       escribe,
    output logic       iniciar,
    output logic [7:0] segundos,
    output logic [7:0] minutos,
    output logic [7:0] horas,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic       ocupado,
    output logic       listo,
    output logic       error
);

`ifdef RTC_CMD_TRANSFER_EN
    localparam bit CMD_EN = 1'b1;
`else
    localparam bit CMD_EN = 1'b0;
`endif

    localparam int          WW     = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);
    localparam logic [2:0]  ULT    = 3'(NUM_REGS - 1);
    localparam logic [2:0]  NREG   = 3'(NUM_REGS);

    typedef enum logic [2:0] {IDLE, CARGA, ESPERA, LIBERA, FIN} estado_t;

    estado_t       estado, estado_d;
    logic [2:0]    idx;
    logic [WW-1:0] wdog;
    logic          pendiente;
    logic          cmd;
    logic [7:0]    regs [NUM_REGS];

    logic wr_ok, ini_wr, ini_rd, avanza, aborta, err_idx;

    assign wr_ok   = wr_indice < NREG;
    assign iniciar = (estado == ESPERA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) estado <= IDLE;
        else        estado <= estado_d;
    end

    always_comb begin
        estado_d = estado;
        ini_wr   = 1'b0;
        ini_rd   = 1'b0;
        avanza   = 1'b0;
        aborta   = 1'b0;
        err_idx  = 1'b0;
        unique case (estado)
            IDLE: begin
                err_idx = req_escritura && !wr_ok;
                if (req_escritura && wr_ok) begin
                    ini_wr   = 1'b1;
                    estado_d = CARGA;
                end else if (req_lectura) begin
                    ini_rd   = 1'b1;
                    estado_d = CARGA;
                end
            end
            CARGA: estado_d = ESPERA;
            ESPERA: begin
                if (final_tx) begin
                    estado_d = LIBERA;
                end else if (wdog == WD_MAX) begin
                    aborta   = 1'b1;
                    estado_d = IDLE;
                end
            end
            LIBERA: begin
                if (!escribe && idx != ULT) begin
                    avanza   = 1'b1;
                    estado_d = CARGA;
                end else if (pendiente || cmd) begin
                    // a queued read (or the read after the command write) chains on
                    ini_rd   = 1'b1;
                    estado_d = CARGA;
                end else begin
                    estado_d = FIN;
                end
            end
            FIN:     estado_d = IDLE;
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            direccion <= '0;
            dato      <= '0;
            escribe   <= 1'b0;
            idx       <= '0;
            wdog      <= '0;
            pendiente <= 1'b0;
            cmd       <= 1'b0;
            ocupado   <= 1'b0;
            listo     <= 1'b0;
            error     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            ocupado <= (estado_d == CARGA) || (estado_d == ESPERA) ||
                       (estado_d == LIBERA);
            listo   <= (estado_d == FIN);
            wdog    <= (estado == ESPERA) ? wdog + WW'(1) : '0;

            if (err_idx || aborta)
                error <= 1'b1;
            else if (estado == IDLE && (ini_wr || ini_rd))
                error <= 1'b0;

            if (aborta) begin
                pendiente <= 1'b0;
                cmd       <= 1'b0;
            end

            if (ini_wr) begin
                escribe   <= 1'b1;
                direccion <= BASE_ADDR + {5'd0, wr_indice};
                dato      <= wr_dato;
                idx       <= wr_indice;
                pendiente <= req_lectura;
            end

            if (ini_rd) begin
                idx       <= '0;
                pendiente <= 1'b0;
                if (CMD_EN && !cmd) begin
                    escribe   <= 1'b1;
                    direccion <= CMD_ADDR;
                    dato      <= CMD_ADDR;
                    cmd       <= 1'b1;
                end else begin
                    escribe   <= 1'b0;
                    direccion <= BASE_ADDR;
                    dato      <= '0;
                    cmd       <= 1'b0;
                end
            end

            if (avanza) begin
                idx       <= idx + 3'd1;
                direccion <= direccion + 8'd1;
            end

            // writes mirror into the holding register so no re-read is needed
            if (estado == ESPERA) begin
                if (escreg && !escribe)
                    regs[idx] <= bus_dato;
                else if (final_tx && escribe && !cmd)
                    regs[idx] <= dato;
            end
        end
    end

    assign segundos = regs[0];
    assign minutos  = regs[1];
    assign horas    = regs[2];
    assign dia      = regs[3];
    assign mes      = regs[4];
    assign anio     = regs[5];

endmodule

// File: tb/tb_rtc_secuenciador.sv
// Self-checking bench for rtc_secuenciador with a simple bus-cycle generator model.
module tb_rtc_secuenciador;

`ifdef RTC_CMD_TRANSFER_EN
    localparam int CX = 1;
`else
    localparam int CX = 0;
`endif

    logic       clk, reset;
    logic       req_lectura, req_escritura;
    logic [2:0] wr_indice;
    logic [7:0] wr_dato;
    logic       final_tx, escreg;
    logic [7:0] bus_dato;
    logic [7:0] direccion, dato;
    logic       escribe, iniciar;
    logic [7:0] segundos, minutos, horas, dia, mes, anio;
    logic       ocupado, listo, error;

    logic       gen_en;
    logic [7:0] rd_base;
    logic [2:0] cnt;
    logic       ini_q;
    logic [16:0] log_q [$];
    int         n_listo, n_ini;
    int         n_chk, n_fail;

    rtc_secuenciador dut (
        .clk(clk), .reset(reset),
        .req_lectura(req_lectura), .req_escritura(req_escritura),
        .wr_indice(wr_indice), .wr_dato(wr_dato),
        .final_tx(final_tx), .escreg(escreg), .bus_dato(bus_dato),
        .direccion(direccion), .dato(dato), .escribe(escribe),
        .iniciar(iniciar),
        .segundos(segundos), .minutos(minutos), .horas(horas),
        .dia(dia), .mes(mes), .anio(anio),
        .ocupado(ocupado), .listo(listo), .error(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // generator: final on the 4th iniciar cycle, read strobe from the 2nd
    initial begin
        cnt      = '0;
        final_tx = 1'b0;
    end
    always @(posedge clk) begin
        if (iniciar && gen_en && !final_tx) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd2) final_tx <= 1'b1;
        end else begin
            cnt      <= '0;
            final_tx <= 1'b0;
        end
    end
    assign escreg   = iniciar && gen_en && !escribe && (cnt != 3'd0);
    assign bus_dato = rd_base + direccion - 8'h21;

    initial begin
        ini_q   = 1'b0;
        n_listo = 0;
        n_ini   = 0;
    end
    always @(posedge clk) begin
        ini_q <= iniciar;
        if (iniciar && !ini_q) log_q.push_back({escribe, dato, direccion});
        if (listo)   n_listo <= n_listo + 1;
        if (iniciar) n_ini   <= n_ini + 1;
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  ind;
        logic [7:0]  wd;
        logic [7:0]  base;
        int          ntr;
        logic [7:0]  f_dir;
        logic [7:0]  f_dat;
        logic        f_esc;
        logic        busy;
        logic        err;
        int          nl;
        logic [47:0] regs;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic pulse(input logic rd, input logic wr,
                         input logic [2:0] ind, input logic [7:0] wd);
        @(negedge clk);
        req_lectura   = rd;
        req_escritura = wr;
        wr_indice     = ind;
        wr_dato       = wd;
        @(negedge clk);
        req_lectura   = 1'b0;
        req_escritura = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        repeat (2) @(negedge clk);
        while (ocupado && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("ocupado_drop", 64'(ocupado), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [47:0] regs_now();
        return {anio, mes, dia, horas, minutos, segundos};
    endfunction

    initial begin
        #1000000;
        $display("FAIL global_watchdog: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lb, nl0, ni0, k;
        n_chk  = 0;
        n_fail = 0;

        vt[0] = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h30, 6 + CX,
                  (CX != 0) ? 8'hF0 : 8'h21, (CX != 0) ? 8'hF0 : 8'h00,
                  1'(CX), 1'b1, 1'b0, 1, 48'h35_34_33_32_31_30};
        vt[1] = '{1'b0, 1'b1, 3'd2, 8'h17, 8'h30, 1,
                  8'h23, 8'h17, 1'b1, 1'b1, 1'b0, 1, 48'h35_34_33_17_31_30};
        vt[2] = '{1'b1, 1'b1, 3'd0, 8'h59, 8'h40, 7 + CX,
                  8'h21, 8'h59, 1'b1, 1'b1, 1'b0, 1, 48'h45_44_43_42_41_40};
        vt[3] = '{1'b0, 1'b1, 3'd6, 8'hAA, 8'h40, 0,
                  8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 0, 48'h45_44_43_42_41_40};
        vt[4] = '{1'b0, 1'b1, 3'd5, 8'h99, 8'h40, 1,
                  8'h26, 8'h99, 1'b1, 1'b1, 1'b0, 1, 48'h99_44_43_42_41_40};
        vt[5] = '{1'b1, 1'b0, 3'd0, 8'h00, 8'hA0, 6 + CX,
                  (CX != 0) ? 8'hF0 : 8'h21, (CX != 0) ? 8'hF0 : 8'h00,
                  1'(CX), 1'b1, 1'b0, 1, 48'hA5_A4_A3_A2_A1_A0};

        reset         = 1'b1;
        req_lectura   = 1'b0;
        req_escritura = 1'b0;
        wr_indice     = '0;
        wr_dato       = '0;
        gen_en        = 1'b1;
        rd_base       = 8'h30;
        #1 reset = 1'b0;
        #1;
        chk("reset_ctl", 64'({direccion, dato, escribe, iniciar,
                              ocupado, listo, error}), 64'd0);
        chk("reset_regs", 64'(regs_now()), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk("reset_release_idle", 64'({iniciar, ocupado}), 64'd0);

        for (int v = 0; v < 6; v++) begin
            lb      = log_q.size();
            nl0     = n_listo;
            rd_base = vt[v].base;
            pulse(vt[v].rd, vt[v].wr, vt[v].ind, vt[v].wd);
            chk($sformatf("v%0d_busy", v), 64'(ocupado), 64'(vt[v].busy));
            wait_idle();
            chk($sformatf("v%0d_error", v), 64'(error), 64'(vt[v].err));
            chk($sformatf("v%0d_regs", v), 64'(regs_now()), 64'(vt[v].regs));
            chk($sformatf("v%0d_ntrans", v), 64'(log_q.size() - lb),
                64'(vt[v].ntr));
            chk($sformatf("v%0d_listo", v), 64'(n_listo - nl0),
                64'(vt[v].nl));
            if (vt[v].ntr != 0)
                chk($sformatf("v%0d_first", v), 64'(log_q[lb]),
                    64'({vt[v].f_esc, vt[v].f_dat, vt[v].f_dir}));
        end

        // watchdog abort: generator never answers
        gen_en  = 1'b0;
        rd_base = 8'h00;
        lb      = log_q.size();
        nl0     = n_listo;
        ni0     = n_ini;
        pulse(1'b1, 1'b0, 3'd0, 8'h00);
        wait_idle();
        chk("to_error", 64'(error), 64'd1);
        chk("to_iniciar", 64'(iniciar), 64'd0);
        chk("to_cycles", 64'(n_ini - ni0), 64'd63);
        chk("to_listo", 64'(n_listo - nl0), 64'd0);
        chk("to_ntrans", 64'(log_q.size() - lb), 64'd1);
        chk("to_regs_kept", 64'(regs_now()), 64'h00_00_A5_A4_A3_A2_A1_A0);

        gen_en  = 1'b1;
        rd_base = 8'h50;
        nl0     = n_listo;
        pulse(1'b1, 1'b0, 3'd0, 8'h00);
        chk("to_err_clear", 64'(error), 64'd0);
        wait_idle();
        chk("to_retry_regs", 64'(regs_now()), 64'h00_00_55_54_53_52_51_50);
        chk("to_retry_listo", 64'(n_listo - nl0), 64'd1);

        // asynchronous reset in the middle of the burst at index 3
        rd_base = 8'h60;
        pulse(1'b1, 1'b0, 3'd0, 8'h00);
        k = 0;
        while (!(iniciar && !escribe && direccion == 8'h24) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reached", 64'(k < 200), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_iniciar", 64'(iniciar), 64'd0);
        chk("mid_ctl", 64'({direccion, dato, escribe, ocupado, listo, error}),
            64'd0);
        chk("mid_regs", 64'(regs_now()), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        rd_base = 8'h70;
        lb      = log_q.size();
        nl0     = n_listo;
        pulse(1'b1, 1'b0, 3'd0, 8'h00);
        wait_idle();
        chk("post_regs", 64'(regs_now()), 64'h00_00_75_74_73_72_71_70);
        chk("post_listo", 64'(n_listo - nl0), 64'd1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("burst_addr%0d", i), 64'(log_q[lb + CX + i][7:0]),
                64'(8'h21 + 8'(i)));
            chk($sformatf("burst_rd%0d", i), 64'(log_q[lb + CX + i][16]),
                64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_secuenciador.md
Name: rtc_secuenciador

Overview:
- Transaction sequencer directly upstream of the RTC bus-cycle generator (the block driving CS/AD/RD/WR).
- Turns host requests into a series of single-byte bus transactions on that block's direccion/dato/escribe/iniciar/final interface.
- Burst-reads the six time registers into holding registers and performs single-register writes.
- Captures read data while the generator's read strobe (escreg) is high.

Parameters:
- BASE_ADDR, 8'h21: RTC address of register index 0 (seconds); index i maps to BASE_ADDR+i.
- NUM_REGS, 6: registers per burst read (seg, min, hora, dia, mes, anio).
- TIMEOUT, 63: max cycles in ESPERA without final before abort.
- CMD_ADDR, 8'hF0: transfer-command address and data (optional feature only).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- req_lectura, in, 1: one-cycle pulse; start burst read.
- req_escritura, in, 1: one-cycle pulse; start single write.
- wr_indice, in, 3: register index for the write (0..NUM_REGS-1).
- wr_dato, in, 8: write data.
- final, in, 1: end-of-transaction from the bus-cycle generator.
- escreg, in, 1: read-data-valid strobe from the bus-cycle generator.
- bus_dato, in, 8: RTC data bus as seen by the FPGA during reads.
- direccion, out, 8: transaction address to the generator.
- dato, out, 8: transaction write data to the generator.
- escribe, out, 1: 1 = write transaction, 0 = read.
- iniciar, out, 1: transaction request level to the generator.
- segundos, minutos, horas, dia, mes, anio, out, 8 each: holding registers.
- ocupado, out, 1: high from request acceptance until return to IDLE.
- listo, out, 1: one-cycle pulse on successful completion.
- error, out, 1: sticky timeout flag; cleared by the next accepted request or by reset.

Behaviour:
- Reset (reset=0, async): every output is 0, the FSM is in IDLE, the pending flag is cleared and the index is 0.
- States:
  - IDLE: waiting for a request.
  - CARGA: drive direccion, dato and escribe; iniciar = 0.
  - ESPERA: iniciar = 1; watchdog counter running.
  - LIBERA: iniciar = 0 for exactly 1 cycle.
  - FIN: pulse listo, clear ocupado.
- IDLE transitions:
  - req_escritura → CARGA with escribe=1, direccion=BASE_ADDR+wr_indice, dato=wr_dato.
  - req_lectura → CARGA with escribe=0, idx=0, direccion=BASE_ADDR, dato=0.
  - ocupado goes high the cycle after the request.
- Both requests in the same IDLE cycle: the write is served first, the read is latched in a 1-deep pending flag, and the read burst starts immediately after the write's LIBERA, with no return to IDLE. listo pulses once, at the end of the read burst.
- Requests while ocupado=1 and not covered by the simultaneous rule are dropped.
- wr_indice ≥ NUM_REGS: request dropped, error set, no bus activity.
- CARGA → ESPERA after 1 cycle. direccion/dato/escribe are stable from CARGA through LIBERA.
- In ESPERA, while escreg=1 and escribe=0, register[idx] <= bus_dato every cycle (last sample wins).
- ESPERA exits:
  - final=1 → LIBERA, iniciar drops the same edge.
  - Watchdog reaches TIMEOUT → iniciar=0, error=1, go to IDLE, no listo, pending cleared, holding registers keep their values.
- LIBERA:
  - Read with idx < NUM_REGS-1: idx+1, direccion+1, → CARGA.
  - Otherwise → FIN (or → CARGA for a pending read).
- FIN: listo=1 for one cycle → IDLE.
- Writes update the matching holding register with wr_dato on final, so the outputs reflect written values without a re-read.
- Latency, read burst: req to listo = NUM_REGS × (2 + T_gen + 1) + 2 cycles, where T_gen is the generator's cycles to final.
- Reset mid-transaction: iniciar falls asynchronously and the generator sees iniciar=0 and idles.

Optional Feature:
- RTC_CMD_TRANSFER_EN defined: each burst read is preceded by one write transaction, direccion=CMD_ADDR and dato=CMD_ADDR, to latch the RTC time into its readable registers. This adds one transaction to the latency. A timeout during this write aborts the whole burst.
- Undefined: the burst starts directly at BASE_ADDR. Port list is identical in both cases.

Test Plan:
- Reset sequence; generator model returning bus_dato = 8'h30+idx → one req_lectura gives 6 transactions at addresses 21..26 with escribe=0; segundos=30 … anio=35; single listo pulse.
- req_escritura with wr_indice=2, wr_dato=8'h17 → one transaction, direccion=23, dato=17, escribe=1; horas=17; listo pulse; no other register changes.
- req_lectura and req_escritura in the same cycle (wr_indice=0, wr_dato=8'h59) → write to 21 first, then a 6-register burst; one listo; segundos ends at the read value.
- Generator model never asserts final → after 63 ESPERA cycles iniciar=0, error=1, ocupado=0, no listo; next req_lectura clears error and completes.
- Assert reset mid-burst at idx=3 → all outputs 0 immediately; after release, a new read completes normally.
- With RTC_CMD_TRANSFER_EN → first transaction has direccion=F0, dato=F0, escribe=1, followed by the 6 reads; without it, the first transaction is at address 21.
